spike_monitor: RTL and testbench

Downstream consumer of the LIF neuron's `spike` output. It counts spikes over a programmable window of back-to-back clock cycles and publishes the count at the end of each window. Independently, it measures the inter-spike interval (ISI) between consecutive spikes. Its outputs drive the spare bidirectional pins so firing rate and ISI can be read off-chip without a logic analyser.

---
 rtl/snn_pkg.sv | 13 +
 rtl/sat_counter.sv | 38 +++
 rtl/spike_monitor.sv | 146 ++++++++++++++
 tb/tb_spike_monitor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and default widths for the SNN spike-monitoring blocks.
package snn_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mon_state_t;

    localparam int SNN_CNT_W = 8;
    localparam int SNN_ISI_W = 8;
    localparam int SNN_WIN_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module sat_counter
    import snn_pkg::*;
#(
    parameter int W = SNN_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    always_comb begin
        // NOTE: assign a default before any branch so no latch is inferred.
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/spike_monitor.sv
// Windowed spike counter plus inter-spike-interval tracker for the LIF neuron output.
module spike_monitor
    import snn_pkg::*;
#(
    parameter int CNT_W = SNN_CNT_W,
    parameter int WIN_W = SNN_WIN_W,
    parameter int ISI_W = SNN_ISI_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             spike,
    input  logic [WIN_W-1:0] win_len,
    output logic [CNT_W-1:0] spike_count,
    output logic             count_valid,
    output logic [ISI_W-1:0] isi,
    output logic             isi_valid,
    output logic             busy
);

    mon_state_t       state_d, state_q;
    logic [WIN_W-1:0] win_cnt_d, win_cnt_q;
    logic [CNT_W-1:0] spike_count_d, spike_count_q;
    logic             count_valid_d, count_valid_q;
    logic [ISI_W-1:0] isi_d, isi_q;
    logic             isi_valid_d, isi_valid_q;
    logic             have_prev_d, have_prev_q;

    logic [CNT_W-1:0] acc;
    logic             acc_clr;
    logic             acc_inc;
    logic [ISI_W-1:0] gap;
    logic             gap_clr;

    logic [WIN_W-1:0] win_len_eff;
    logic             terminal;
    logic [CNT_W-1:0] acc_final;
    logic [ISI_W:0]   gap_plus;
    logic [ISI_W-1:0] isi_sat;

    sat_counter #(.W(CNT_W)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .inc   (acc_inc),
        .q     (acc)
    );

    sat_counter #(.W(ISI_W)) u_gap (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (gap_clr),
        .inc   (en),
        .q     (gap)
    );

    assign win_len_eff = (win_len == '0) ? WIN_W'(1) : win_len;
    assign terminal    = (win_cnt_q == WIN_W'(1));
    // The terminal-cycle spike belongs to the window that is closing.
    assign acc_final   = (spike && (acc != '1)) ? acc + CNT_W'(1) : acc;
    assign gap_plus    = {1'b0, gap} + (ISI_W + 1)'(1);
    assign isi_sat     = gap_plus[ISI_W] ? '1 : gap_plus[ISI_W-1:0];

    always_comb begin
        state_d       = state_q;
        win_cnt_d     = win_cnt_q;
        spike_count_d = spike_count_q;
        count_valid_d = 1'b0;
        acc_clr       = 1'b0;
        acc_inc       = 1'b0;
        case (state_q)
            IDLE: begin
                acc_clr = 1'b1;
                if (en) begin
                    state_d   = RUN;
                    win_cnt_d = win_len_eff;
                end
            end
            RUN: begin
                if (terminal) begin
                    spike_count_d = acc_final;
                    count_valid_d = 1'b1;
                    acc_clr       = 1'b1;
                    if (en) begin
                        win_cnt_d = win_len_eff;
                    end else begin
                        state_d   = IDLE;
                        win_cnt_d = '0;
                    end
                end else if (!en) begin
                    state_d   = IDLE;
                    win_cnt_d = '0;
                    acc_clr   = 1'b1;
                end else begin
                    win_cnt_d = win_cnt_q - WIN_W'(1);
                    acc_inc   = spike;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Interval tracking ignores the window FSM and only cares about en.
    always_comb begin
        isi_d       = isi_q;
        isi_valid_d = 1'b0;
        have_prev_d = have_prev_q;
        gap_clr     = !en || spike;
        if (!en) begin
            have_prev_d = 1'b0;
        end else if (spike) begin
            have_prev_d = 1'b1;
            if (have_prev_q) begin
                isi_d       = isi_sat;
                isi_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            win_cnt_q     <= '0;
            spike_count_q <= '0;
            count_valid_q <= 1'b0;
            isi_q         <= '0;
            isi_valid_q   <= 1'b0;
            have_prev_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_cnt_q     <= win_cnt_d;
            spike_count_q <= spike_count_d;
            count_valid_q <= count_valid_d;
            isi_q         <= isi_d;
            isi_valid_q   <= isi_valid_d;
            have_prev_q   <= have_prev_d;
        end
    end

    assign spike_count = spike_count_q;
    assign count_valid = count_valid_q;
    assign isi         = isi_q;
    assign isi_valid   = isi_valid_q;
    assign busy        = (state_q == RUN);

endmodule

// File: tb/tb_spike_monitor.sv
// Directed bench for spike_monitor: window-count vector table plus hand-written corner sequences.
module tb_spike_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       spike;
    logic [7:0] win_len;

    logic [7:0] spike_count;
    logic       count_valid;
    logic [7:0] isi;
    logic       isi_valid;
    logic       busy;

    logic [3:0] s_spike_count;
    logic       s_count_valid;
    logic [3:0] s_isi;
    logic       s_isi_valid;
    logic       s_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spike_monitor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .spike       (spike),
        .win_len     (win_len),
        .spike_count (spike_count),
        .count_valid (count_valid),
        .isi         (isi),
        .isi_valid   (isi_valid),
        .busy        (busy)
    );

    // Narrow instance sharing the same stimulus, used for the saturation cases.
    spike_monitor #(.CNT_W(4), .WIN_W(8), .ISI_W(4)) dut_s (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .spike       (spike),
        .win_len     (win_len),
        .spike_count (s_spike_count),
        .count_valid (s_count_valid),
        .isi         (s_isi),
        .isi_valid   (s_isi_valid),
        .busy        (s_busy)
    );

    typedef struct {
        logic [7:0]  win_len;
        logic [31:0] pattern;   // bit j-1 = spike in window cycle j
        logic [7:0]  exp_count;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int eff;

        vecs[0] = '{8'd10, 32'h0000_0155, 8'd5};
        vecs[1] = '{8'd4,  32'h0000_000F, 8'd4};
        vecs[2] = '{8'd5,  32'h0000_0010, 8'd1};
        vecs[3] = '{8'd1,  32'h0000_0001, 8'd1};
        vecs[4] = '{8'd0,  32'h0000_0001, 8'd1};
        vecs[5] = '{8'd7,  32'h0000_0000, 8'd0};
        vecs[6] = '{8'd3,  32'h0000_0003, 8'd2};

        rst_n = 1'b0; en = 1'b0; spike = 1'b0; win_len = 8'd0;
        #12;
        check("rst_spike_count", spike_count, 0);
        check("rst_count_valid", count_valid, 0);
        check("rst_isi", isi, 0);
        check("rst_isi_valid", isi_valid, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick;

        // Table: three back-to-back windows per record, en held high.
        for (int v = 0; v < 7; v++) begin
            en = 1'b0; spike = 1'b0;
            tick; tick;
            check("tbl_idle_busy", busy, 0);
            en = 1'b1;
            win_len = vecs[v].win_len;
            tick;
            check("tbl_run_busy", busy, 1);
            eff = (vecs[v].win_len == 8'd0) ? 1 : int'(vecs[v].win_len);
            for (int w = 0; w < 3; w++) begin
                for (int j = 1; j <= eff; j++) begin
                    spike = vecs[v].pattern[j-1];
                    tick;
                    check("tbl_count_valid", count_valid, (j == eff));
                    if (j == eff) check("tbl_spike_count", spike_count, vecs[v].exp_count);
                end
            end
            spike = 1'b0;
        end

        // ISI: spikes at cycles 3, 8, 9 after enable.
        en = 1'b0; spike = 1'b0;
        tick; tick;
        en = 1'b1; win_len = 8'd100;
        for (int c = 1; c <= 12; c++) begin
            spike = (c == 3 || c == 8 || c == 9);
            tick;
            check("isi_valid_pulse", isi_valid, (c == 8 || c == 9));
            if (c == 8) check("isi_5", isi, 5);
            if (c == 9) check("isi_1", isi, 1);
        end
        spike = 1'b0;
        check("isi_hold", isi, 1);

        // ISI saturation: spikes 40 cycles apart.
        en = 1'b0;
        tick;
        en = 1'b1;
        for (int c = 1; c <= 41; c++) begin
            spike = (c == 1 || c == 41);
            tick;
            if (c == 1) check("isi_first_no_pulse", isi_valid, 0);
        end
        spike = 1'b0;
        check("isi40_valid", isi_valid, 1);
        check("isi40_value", isi, 40);
        check("isi_sat_valid", s_isi_valid, 1);
        check("isi_sat_value", s_isi, 15);

        // Count saturation: win_len 20, spike always high.
        en = 1'b0;
        tick; tick;
        en = 1'b1; win_len = 8'd20;
        tick;
        spike = 1'b1;
        for (int j = 1; j <= 20; j++) tick;
        check("cnt20_valid", count_valid, 1);
        check("cnt20_value", spike_count, 20);
        check("cnt_sat_valid", s_count_valid, 1);
        check("cnt_sat_value", s_spike_count, 15);

        // Abort at RUN cycle 5 of 10 after one completed window.
        spike = 1'b0; en = 1'b0;
        tick; tick;
        en = 1'b1; win_len = 8'd10;
        tick;
        spike = 1'b1;
        for (int j = 1; j <= 10; j++) tick;
        check("abort_prev_count", spike_count, 10);
        for (int j = 1; j <= 4; j++) tick;
        en = 1'b0;
        tick;
        check("abort_busy", busy, 0);
        check("abort_no_valid", count_valid, 0);
        spike = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick;
            check("abort_quiet", count_valid, 0);
        end
        check("abort_count_held", spike_count, 10);

        // en falling on the terminal cycle, with a terminal-cycle spike.
        en = 1'b1; win_len = 8'd4; spike = 1'b0;
        tick;
        for (int j = 1; j <= 3; j++) tick;
        spike = 1'b1; en = 1'b0;
        tick;
        check("term_fall_valid", count_valid, 1);
        check("term_fall_count", spike_count, 1);
        check("term_fall_busy", busy, 0);
        spike = 1'b0;
        tick;
        check("term_fall_pulse_end", count_valid, 0);

        // Reset asserted during RUN cycle 4 of an 8-cycle window.
        en = 1'b1; win_len = 8'd8;
        tick;
        spike = 1'b1;
        for (int j = 1; j <= 3; j++) tick;
        spike = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_spike_count", spike_count, 0);
        check("midrst_count_valid", count_valid, 0);
        check("midrst_isi", isi, 0);
        check("midrst_isi_valid", isi_valid, 0);
        check("midrst_busy", busy, 0);
        en = 1'b0;
        #4;
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick;
            check("postrst_quiet", {count_valid, isi_valid, busy}, 0);
        end

        // win_len change mid-window only takes effect at the reload.
        en = 1'b1; win_len = 8'd3;
        tick;
        win_len = 8'd6; spike = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            tick;
            check("wl_change_first", count_valid, (j == 3));
        end
        check("wl_change_count3", spike_count, 3);
        for (int j = 1; j <= 6; j++) begin
            tick;
            check("wl_change_second", count_valid, (j == 6));
        end
        check("wl_change_count6", spike_count, 6);

        // win_len 0 with a single spike: publishes every cycle.
        spike = 1'b0; en = 1'b0;
        tick; tick;
        en = 1'b1; win_len = 8'd0;
        tick;
        for (int c = 1; c <= 5; c++) begin
            spike = (c == 3);
            tick;
            check("wl0_valid", count_valid, 1);
            check("wl0_count", spike_count, (c == 3) ? 1 : 0);
        end
        spike = 1'b0; en = 1'b0;
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
